// File: rtl/lemmings_pkg.sv
// Shared state type and state-classification helpers for the lemming walker.
package lemmings_pkg;

  typedef enum logic [2:0] {
    WALK_L,
    WALK_R,
    FALL_L,
    FALL_R,
    DIG_L,
    DIG_R,
    SPLAT
  } state_t;

  function automatic logic is_fall(input state_t s);
    return (s == FALL_L) || (s == FALL_R);
  endfunction

  function automatic logic dir_left(input state_t s);
    return (s == WALK_L) || (s == FALL_L) || (s == DIG_L);
  endfunction

endpackage

// File: rtl/lemmings_fall_counter.sv
// Saturating count of consecutive falling cycles; flags when a landing would be fatal.
module lemmings_fall_counter #(
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = $clog2(FALL_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic falling,
  output logic over_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at LIMIT rather than wrapping, so arbitrarily long falls stay fatal.
  always_comb begin
    cnt_d = '0;
    if (falling) begin
      if (cnt_q < LIMIT) cnt_d = cnt_q + CNT_W'(1);
      else               cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign over_limit = (cnt_q >= LIMIT);

endmodule

// File: rtl/lemmings_walker.sv
// Lemming behaviour engine: walk, dig, fall and splat, with Moore outputs.
module lemmings_walker
  import lemmings_pkg::*;
#(
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = $clog2(FALL_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  state_t state_q;
  state_t state_d;
  logic   over_limit;

  lemmings_fall_counter #(
    .FALL_LIMIT(FALL_LIMIT),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .falling   (is_fall(state_q)),
    .over_limit(over_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WALK_L;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = WALK_L;
    case (state_q)
      WALK_L: begin
        if (!ground)       state_d = FALL_L;
        else if (dig)      state_d = DIG_L;
        else if (bump_left) state_d = WALK_R;
        else               state_d = WALK_L;
      end
      WALK_R: begin
        if (!ground)        state_d = FALL_R;
        else if (dig)       state_d = DIG_R;
        else if (bump_right) state_d = WALK_L;
        else                state_d = WALK_R;
      end
      DIG_L:   state_d = ground ? DIG_L : FALL_L;
      DIG_R:   state_d = ground ? DIG_R : FALL_R;
      // Landing always resumes walking in the fall direction, never digging.
      FALL_L, FALL_R: begin
        if (!ground)         state_d = state_q;
        else if (over_limit) state_d = SPLAT;
        else                 state_d = dir_left(state_q) ? WALK_L : WALK_R;
      end
      SPLAT:   state_d = SPLAT;
      default: state_d = WALK_L;
    endcase
  end

  always_comb begin
    walk_left  = (state_q == WALK_L);
    walk_right = (state_q == WALK_R);
    aaah       = is_fall(state_q);
    digging    = (state_q == DIG_L) || (state_q == DIG_R);
    splat      = (state_q == SPLAT);
  end

endmodule

// File: tb/tb_lemmings_walker.sv
// Directed bench for lemmings_walker with FALL_LIMIT=20 and FALL_LIMIT=3 instances.
module tb_lemmings_walker;

  logic clk = 1'b0;
  logic rst;
  logic bump_left, bump_right, ground, dig;
  logic wl20, wr20, aa20, dg20, sp20;
  logic wl3, wr3, aa3, dg3, sp3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [4:0] O_WL = 5'b10000;
  localparam logic [4:0] O_WR = 5'b01000;
  localparam logic [4:0] O_FA = 5'b00100;
  localparam logic [4:0] O_DG = 5'b00010;
  localparam logic [4:0] O_SP = 5'b00001;

  logic [4:0] outs20, outs3;
  assign outs20 = {wl20, wr20, aa20, dg20, sp20};
  assign outs3  = {wl3, wr3, aa3, dg3, sp3};

  always #5 clk = ~clk;

  lemmings_walker #(.FALL_LIMIT(20)) u_dut20 (
    .clk(clk), .rst(rst), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(wl20), .walk_right(wr20),
    .aaah(aa20), .digging(dg20), .splat(sp20)
  );

  lemmings_walker #(.FALL_LIMIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bump_left(bump_left), .bump_right(bump_right),
    .ground(ground), .dig(dig), .walk_left(wl3), .walk_right(wr3),
    .aaah(aa3), .digging(dg3), .splat(sp3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bump_left = 1'b0; bump_right = 1'b0; ground = 1'b1; dig = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (outs20 !== O_WL) $display("FAIL reset_outs: got %b want %b", outs20, O_WL);
    else pass_cnt++;
    total_cnt++;
    if (u_dut20.u_cnt.cnt_q !== 5'd0) $display("FAIL reset_cnt: got %0d want 0", u_dut20.u_cnt.cnt_q);
    else pass_cnt++;
  endtask

  task automatic test_bump();
    logic [4:0] exp;
    do_reset();
    bump_left = 1'b1; step(); bump_left = 1'b0;
    total_cnt++;
    if (outs20 !== O_WR) $display("FAIL bump_left: got %b want %b", outs20, O_WR);
    else pass_cnt++;
    bump_right = 1'b1; step(); bump_right = 1'b0;
    total_cnt++;
    if (outs20 !== O_WL) $display("FAIL bump_right: got %b want %b", outs20, O_WL);
    else pass_cnt++;
    bump_left = 1'b1; bump_right = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = (i % 2 == 0) ? O_WR : O_WL;
      total_cnt++;
      if (outs20 !== exp) $display("FAIL bump_both_%0d: got %b want %b", i, outs20, exp);
      else pass_cnt++;
    end
    bump_left = 1'b0; bump_right = 1'b0;
  endtask

  task automatic test_fall_walk_r();
    do_reset();
    bump_left = 1'b1; step(); bump_left = 1'b0;
    ground = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bump_left = (i == 3); dig = (i == 3);
      step();
      total_cnt++;
      if (outs20 !== O_FA) $display("FAIL fall_r_cycle%0d: got %b want %b", i, outs20, O_FA);
      else pass_cnt++;
    end
    bump_left = 1'b0; dig = 1'b0; ground = 1'b1;
    step();
    total_cnt++;
    if (outs20 !== O_WR) $display("FAIL fall_r_land: got %b want %b", outs20, O_WR);
    else pass_cnt++;
  endtask

  task automatic test_dig();
    do_reset();
    dig = 1'b1; step(); dig = 1'b0;
    total_cnt++;
    if (outs20 !== O_DG) $display("FAIL dig_start: got %b want %b", outs20, O_DG);
    else pass_cnt++;
    bump_left = 1'b1; bump_right = 1'b1; dig = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (outs20 !== O_DG) $display("FAIL dig_hold_%0d: got %b want %b", i, outs20, O_DG);
      else pass_cnt++;
    end
    bump_left = 1'b0; bump_right = 1'b0; dig = 1'b0; ground = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total_cnt++;
      if (outs20 !== O_FA) $display("FAIL dig_fall_%0d: got %b want %b", i, outs20, O_FA);
      else pass_cnt++;
    end
    ground = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (outs20 !== O_WL) $display("FAIL dig_land_%0d: got %b want %b", i, outs20, O_WL);
      else pass_cnt++;
    end
  endtask

  task automatic test_limit20();
    do_reset();
    ground = 1'b0;
    repeat (20) step();
    ground = 1'b1; step();
    total_cnt++;
    if (outs20 !== O_WL) $display("FAIL fall20_survive: got %b want %b", outs20, O_WL);
    else pass_cnt++;
    ground = 1'b0;
    repeat (21) step();
    ground = 1'b1; step();
    total_cnt++;
    if (outs20 !== O_SP) $display("FAIL fall21_splat: got %b want %b", outs20, O_SP);
    else pass_cnt++;
    for (int i = 0; i < 50; i++) begin
      bump_left = 1'($urandom_range(0, 1)); bump_right = 1'($urandom_range(0, 1));
      ground = 1'($urandom_range(0, 1)); dig = 1'($urandom_range(0, 1));
      step();
      total_cnt++;
      if (outs20 !== O_SP) $display("FAIL splat_hold_%0d: got %b want %b", i, outs20, O_SP);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    ground = 1'b0;
    repeat (1500) step();
    total_cnt++;
    if (u_dut20.u_cnt.cnt_q !== 5'd20) $display("FAIL sat_cnt: got %0d want 20", u_dut20.u_cnt.cnt_q);
    else pass_cnt++;
    ground = 1'b1; step();
    total_cnt++;
    if (outs20 !== O_SP) $display("FAIL sat_splat: got %b want %b", outs20, O_SP);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    ground = 1'b0;
    repeat (10) step();
    total_cnt++;
    if (u_dut20.u_cnt.cnt_q !== 5'd9) $display("FAIL midfall_cnt: got %0d want 9", u_dut20.u_cnt.cnt_q);
    else pass_cnt++;
    ground = 1'b1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (outs20 !== O_WL) $display("FAIL async_rst_outs: got %b want %b", outs20, O_WL);
    else pass_cnt++;
    total_cnt++;
    if (u_dut20.u_cnt.cnt_q !== 5'd0) $display("FAIL async_rst_cnt: got %0d want 0", u_dut20.u_cnt.cnt_q);
    else pass_cnt++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_ground_dig_priority();
    do_reset();
    ground = 1'b0; dig = 1'b1; step();
    total_cnt++;
    if (outs20 !== O_FA) $display("FAIL ground_over_dig: got %b want %b", outs20, O_FA);
    else pass_cnt++;
    ground = 1'b1; dig = 1'b0; step();
    total_cnt++;
    if (outs20 !== O_WL) $display("FAIL ground_over_dig_land: got %b want %b", outs20, O_WL);
    else pass_cnt++;
  endtask

  task automatic test_limit3();
    do_reset();
    ground = 1'b0;
    repeat (3) step();
    ground = 1'b1; step();
    total_cnt++;
    if (outs3 !== O_WL) $display("FAIL lim3_fall3: got %b want %b", outs3, O_WL);
    else pass_cnt++;
    ground = 1'b0;
    repeat (4) step();
    ground = 1'b1; step();
    total_cnt++;
    if (outs3 !== O_SP) $display("FAIL lim3_fall4: got %b want %b", outs3, O_SP);
    else pass_cnt++;
    total_cnt++;
    if (outs20 !== O_WL) $display("FAIL lim20_fall4: got %b want %b", outs20, O_WL);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_bump();
    test_fall_walk_r();
    test_dig();
    test_limit20();
    test_saturate();
    test_async_reset();
    test_ground_dig_priority();
    test_limit3();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
